// File: rtl/bram_ctl_pkg.sv
// Shared widths, sizing helpers and response-type encoding for the BRAM port controller.
package bram_ctl_pkg;

  localparam int DEF_NUM_COL   = 16;
  localparam int DEF_COL_WIDTH = 32;
  localparam int DEF_DATA_W    = DEF_NUM_COL * DEF_COL_WIDTH;

  // Response-type bit carried alongside data in the response FIFO
  localparam logic RSP_TYPE_RD = 1'b0;
  localparam logic RSP_TYPE_WR = 1'b1;

  function automatic int data_w(input int num_col, input int col_width);
    return num_col * col_width;
  endfunction

  // Pointer width: indexes 0..depth-1
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Count width: represents 0..depth
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_port_ctl_rsp_fifo.sv
// Synchronous response FIFO with registered valid/count; pointers wrap modulo DEPTH
// so non-power-of-two depths work. Storage is not reset; only pointers and count are.
module bram_port_ctl_rsp_fifo
  import bram_ctl_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop & valid;
  assign pop_data = mem[rd_ptr];

  // Next occupancy; push and pop together leave the count unchanged even when full
  always_comb begin
    count_nxt = count;
    case ({push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointer, count and valid bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

  // Entry storage
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bram_port_ctl.sv
// bram_port_ctl: drives one port of a byte-enable, write-first BRAM (1-cycle read
// latency) from a valid/ready request stream, returning read data through a
// credit-managed response FIFO so consumer backpressure never drops data.
// Optional build macro BRAM_PORT_CTL_WR_ACK_EN: writes also consume a credit and
// return one acknowledge response (rsp_is_wr=1) carrying the write-first row.
module bram_port_ctl
  import bram_ctl_pkg::*;
#(
  parameter int NUM_COL    = 16,
  parameter int COL_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wr,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_COL-1:0]            req_be,
  input  logic [NUM_COL*COL_WIDTH-1:0]  req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NUM_COL*COL_WIDTH-1:0]  rsp_data,
  output logic                          rsp_is_wr,
  output logic [NUM_COL-1:0]            bram_wen,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [NUM_COL*COL_WIDTH-1:0]  bram_din,
  input  logic [NUM_COL*COL_WIDTH-1:0]  bram_dout
);

  localparam int DATA_W = data_w(NUM_COL, COL_WIDTH);
  localparam int CNT_W  = cnt_w(RSP_DEPTH);

  logic             rd_vld_p1;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_valid;
  logic             credit_ok;
  logic             req_fire;
  logic             takes_credit;
  logic             rsp_pop;

  // ---- p0: request accept and BRAM drive
  // Credit comes only from registered state, so rsp_ready never reaches req_ready.
  assign credit_ok = (int'(fifo_count) + int'(rd_vld_p1)) < RSP_DEPTH;
  assign req_fire  = req_valid & req_ready;
  assign bram_addr = req_addr;
  assign bram_din  = req_data;
  assign bram_wen  = (req_fire & req_wr) ? req_be : '0;

  // Marks an op accepted last cycle whose BRAM output must be captured now
  always_ff @(posedge clock) begin
    if (reset) rd_vld_p1 <= 1'b0;
    else       rd_vld_p1 <= takes_credit;
  end

  // ---- p1: capture bram_dout into the response FIFO
  assign rsp_valid = fifo_valid & ~reset;
  assign rsp_pop   = rsp_valid & rsp_ready;

`ifdef BRAM_PORT_CTL_WR_ACK_EN
  logic              rd_is_wr_p1;
  logic [DATA_W:0]   fifo_dout;

  assign req_ready    = ~reset & credit_ok;
  assign takes_credit = req_fire;

  // Remembers whether the op in flight was a write so its response is tagged as an ack
  always_ff @(posedge clock) begin
    rd_is_wr_p1 <= req_wr;
  end

  bram_port_ctl_rsp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_vld_p1),
    .push_data ({(rd_is_wr_p1 ? RSP_TYPE_WR : RSP_TYPE_RD), bram_dout}),
    .pop       (rsp_pop),
    .pop_data  (fifo_dout),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  // ---- p2: response presentation, zeroed whenever nothing is offered
  assign rsp_data  = rsp_valid ? fifo_dout[DATA_W-1:0] : '0;
  assign rsp_is_wr = rsp_valid & (fifo_dout[DATA_W] == RSP_TYPE_WR);
`else
  logic [DATA_W-1:0] fifo_dout;

  // Writes never produce a response, so they need no credit
  assign req_ready    = ~reset & (req_wr | credit_ok);
  assign takes_credit = req_fire & ~req_wr;

  bram_port_ctl_rsp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_vld_p1),
    .push_data (bram_dout),
    .pop       (rsp_pop),
    .pop_data  (fifo_dout),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  // ---- p2: response presentation, zeroed whenever nothing is offered
  assign rsp_data  = rsp_valid ? fifo_dout : '0;
  assign rsp_is_wr = 1'b0;
`endif

endmodule

// File: tb/tb_bram_port_ctl.sv
// Directed bench for bram_port_ctl with a behavioural write-first BRAM attached.
`timescale 1ns/1ps
module tb_bram_port_ctl;

  localparam int NUM_COL    = 16;
  localparam int COL_WIDTH  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int RSP_DEPTH  = 4;
  localparam int DW         = NUM_COL * COL_WIDTH;
`ifdef BRAM_PORT_CTL_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [NUM_COL-1:0]    req_be;
  logic [DW-1:0]         req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic                  rsp_is_wr;
  logic [NUM_COL-1:0]    bram_wen;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DW-1:0]         bram_din;
  logic [DW-1:0]         bram_dout;

  int n_vec = 0;
  int n_bad = 0;
  bit ovf_seen = 1'b0;

  always #5 clock = ~clock;

  bram_port_ctl #(
    .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_be(req_be), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_is_wr(rsp_is_wr),
    .bram_wen(bram_wen), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // Write-first byte-enable BRAM, registered output
  logic [DW-1:0] mem [1<<ADDR_WIDTH];
  always @(posedge clock) begin : bram_model
    logic [DW-1:0] row;
    row = mem[bram_addr];
    for (int c = 0; c < NUM_COL; c++)
      if (bram_wen[c]) row[c*COL_WIDTH +: COL_WIDTH] = bram_din[c*COL_WIDTH +: COL_WIDTH];
    mem[bram_addr] <= row;
    bram_dout      <= row;
  end

  // Credit must keep FIFO occupancy plus in-flight within the depth
  always @(negedge clock) begin
    if (!reset && (int'(dut.fifo_count) + int'(dut.rd_vld_p1) > RSP_DEPTH)) ovf_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_COL-1:0]    be;
    logic [DW-1:0]         data;
    logic [DW-1:0]         exp;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [DW-1:0] pat(input logic [31:0] col);
    return {NUM_COL{col}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic wr, input logic [ADDR_WIDTH-1:0] a,
                         input logic [NUM_COL-1:0] be, input logic [DW-1:0] d, input logic [DW-1:0] e);
    tbl[i].wr = wr; tbl[i].addr = a; tbl[i].be = be; tbl[i].data = d; tbl[i].exp = e;
  endtask

  // One request; returns after the handshake edge (+1ns), ok=0 if never accepted
  task automatic send(input logic wr, input logic [ADDR_WIDTH-1:0] a, input logic [NUM_COL-1:0] be,
                      input logic [DW-1:0] d, output bit ok);
    int g;
    @(negedge clock);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_be = be; req_data = d;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clock); g++; end
    ok = req_ready;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  // Cycles from handshake edge to the first cycle rsp_valid is seen
  task automatic wait_rsp(output bit got, output int lat);
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (rsp_valid) begin got = 1'b1; lat = k; break; end
    end
  endtask

  // Streaming reads of addresses base..base+n-1, one cycle per step
  int s_base, s_n, s_sent, s_got, s_drops;
  task automatic stream_start(input int base, input int n);
    s_base = base; s_n = n; s_sent = 0; s_got = 0; s_drops = 0;
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b0; req_be = '0; req_addr = ADDR_WIDTH'(base);
  endtask

  task automatic stream_step(input string name);
    bit fire;
    if (rsp_valid && rsp_ready) begin
      chk(name, rsp_data, pat(32'h5000_0000 + 32'(s_base + s_got)));
      chk({name, "_is_wr"}, DW'(rsp_is_wr), DW'(0));
      s_got++;
    end
    fire = req_valid && req_ready;
    if (req_valid && !req_ready) s_drops++;
    @(posedge clock); #1;
    if (fire) begin
      s_sent++;
      if (s_sent == s_n) req_valid = 1'b0;
      else req_addr = ADDR_WIDTH'(s_base + s_sent);
    end
    @(negedge clock);
  endtask

  initial begin
    bit ok, got, saw;
    int lat, n_exp, idx;
    logic [DW-1:0] h;

    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_be = '0; req_data = '0;
    rsp_ready = 1'b1;

    set_vec(0,  1'b1, 5'd3,  16'hFFFF, pat(32'hAAAA_0003), pat(32'hAAAA_0003));
    set_vec(1,  1'b0, 5'd3,  16'h0000, '0,                 pat(32'hAAAA_0003));
    set_vec(2,  1'b1, 5'd5,  16'hFFFF, pat(32'hBBBB_0005), pat(32'hBBBB_0005));
    set_vec(3,  1'b1, 5'd5,  16'h0001, pat(32'hCCCC_0005), {{15{32'hBBBB_0005}}, 32'hCCCC_0005});
    set_vec(4,  1'b0, 5'd5,  16'h0000, '0,                 {{15{32'hBBBB_0005}}, 32'hCCCC_0005});
    set_vec(5,  1'b1, 5'd31, 16'h8000, pat(32'hDDDD_001F), {32'hDDDD_001F, {15{32'h5000_001F}}});
    set_vec(6,  1'b0, 5'd31, 16'h0000, '0,                 {32'hDDDD_001F, {15{32'h5000_001F}}});
    set_vec(7,  1'b1, 5'd0,  16'h0000, pat(32'hEEEE_0000), pat(32'h5000_0000));
    set_vec(8,  1'b0, 5'd0,  16'h0000, '0,                 pat(32'h5000_0000));
    set_vec(9,  1'b1, 5'd7,  16'h00F0, pat(32'h6666_0007),
            {{8{32'h5000_0007}}, {4{32'h6666_0007}}, {4{32'h5000_0007}}});
    set_vec(10, 1'b0, 5'd7,  16'h0000, '0,
            {{8{32'h5000_0007}}, {4{32'h6666_0007}}, {4{32'h5000_0007}}});
    set_vec(11, 1'b0, 5'd12, 16'h0000, '0,                 pat(32'h5000_000C));

    // Reset state, with a write offered to prove bram_wen stays gated
    repeat (2) @(posedge clock);
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b1; req_be = 16'hFFFF; #1;
    chk("rst_req_ready", DW'(req_ready), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("rst_rsp_is_wr", DW'(rsp_is_wr), DW'(0));
    chk("rst_rsp_data",  rsp_data,        '0);
    chk("rst_bram_wen",  DW'(bram_wen),   DW'(0));
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Fill every word with a known pattern
    for (int i = 0; i < 32; i++) begin
      send(1'b1, ADDR_WIDTH'(i), 16'hFFFF, pat(32'h5000_0000 + 32'(i)), ok);
      if (!ok) chk($sformatf("init_wr%0d_ready", i), DW'(ok), DW'(1));
    end
    repeat (4) @(negedge clock);

    // Back-to-back reads of the whole array with a free-running consumer
    stream_start(0, 32);
    for (int cyc = 0; cyc < 200 && s_got < 32; cyc++) stream_step("b2b_data");
    chk("b2b_count",    DW'(s_got),   DW'(32));
    chk("b2b_no_stall", DW'(s_drops), DW'(0));

    // Table of single transactions
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].data, ok);
      chk($sformatf("tbl%0d_ready", i), DW'(ok), DW'(1));
      if (!tbl[i].wr || WR_ACK) begin
        wait_rsp(got, lat);
        chk($sformatf("tbl%0d_rsp_valid", i), DW'(got), DW'(1));
        chk($sformatf("tbl%0d_rsp_data", i),  rsp_data, tbl[i].exp);
        chk($sformatf("tbl%0d_rsp_is_wr", i), DW'(rsp_is_wr), DW'(tbl[i].wr));
      end else begin
        saw = 1'b0;
        repeat (3) begin @(negedge clock); if (rsp_valid) saw = 1'b1; end
        chk($sformatf("tbl%0d_no_rsp", i), DW'(saw), DW'(0));
      end
    end

    // Exact read latency
    send(1'b0, 5'd3, '0, '0, ok);
    wait_rsp(got, lat);
    chk("lat_cycles",   DW'(lat), DW'(2));
    chk("lat_rsp_data", rsp_data, pat(32'hAAAA_0003));
    chk("lat_is_wr",    DW'(rsp_is_wr), DW'(0));

    // Read on the cycle right after a write to the same address
    h = pat(32'h9999_0009);
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd9; req_be = 16'hFFFF; req_data = h;
    #1 chk("haz_wr_ready", DW'(req_ready), DW'(1));
    @(posedge clock); #1;
    req_wr = 1'b0;
    @(negedge clock);
    chk("haz_rd_ready", DW'(req_ready), DW'(1));
    @(posedge clock); #1;
    req_valid = 1'b0;
    n_exp = WR_ACK ? 2 : 1;
    idx = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rsp_valid) begin
        chk("haz_rsp_data",  rsp_data, h);
        chk("haz_rsp_is_wr", DW'(rsp_is_wr), DW'((WR_ACK && idx == 0) ? 1 : 0));
        idx++;
      end
    end
    chk("haz_rsp_count", DW'(idx), DW'(n_exp));

    // Consumer stalled: only RSP_DEPTH reads may be taken, then all drain in order
    rsp_ready = 1'b0;
    stream_start(10, 10);
    repeat (12) stream_step("bp_data");
    chk("bp_accepted",   DW'(s_sent),    DW'(4));
    chk("bp_req_ready",  DW'(req_ready), DW'(0));
    chk("bp_rsp_valid",  DW'(rsp_valid), DW'(1));
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && s_got < 10; cyc++) stream_step("bp_data");
    chk("bp_returned", DW'(s_got),  DW'(10));
    chk("bp_sent",     DW'(s_sent), DW'(10));

    // Reset with one read in flight and three queued
    rsp_ready = 1'b0;
    stream_start(20, 4);
    for (int cyc = 0; cyc < 20 && s_sent < 4; cyc++) stream_step("pre_rst_data");
    chk("pre_rst_sent",      DW'(s_sent),    DW'(4));
    chk("pre_rst_req_ready", DW'(req_ready), DW'(0));
    reset = 1'b1; #1;
    chk("in_rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("in_rst_req_ready", DW'(req_ready), DW'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_rsp_valid", DW'(rsp_valid), DW'(0));
    @(negedge clock);
    chk("post_rst_dropped", DW'(rsp_valid), DW'(0));
    rsp_ready = 1'b1;
    send(1'b0, 5'd3, '0, '0, ok);
    chk("post_rst_ready", DW'(ok), DW'(1));
    wait_rsp(got, lat);
    chk("post_rst_lat",  DW'(lat), DW'(2));
    chk("post_rst_data", rsp_data, pat(32'hAAAA_0003));

    repeat (3) @(negedge clock);
    chk("no_overflow", DW'(ovf_seen), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
